nubus_master_sched: RTL and testbench

// - Shares the single NuBus master port between NREQ local requesters (CPU core, DMA engines) with round-robin arbitration.
// - Sits between the requesters and the nubus top-level cpu_* master interface.
// - Owns ordering, lock hold and timeout (bus error) for every master transfer.

---
 rtl/nubus_master_sched.sv | 162 ++++++++++++++++
 tb/tb_nubus_master_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_master_sched.sv
// rtl/nubus_master_sched.sv - round-robin sharing of the NuBus master port with lock hold and timeout
module nubus_master_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                 nub_clkn,
    input  logic                 nub_resetn,
    input  logic [NREQ-1:0]      rq_valid,
    input  logic [32*NREQ-1:0]   rq_addr,
    input  logic [32*NREQ-1:0]   rq_wdata,
    input  logic [4*NREQ-1:0]    rq_write,
    input  logic [NREQ-1:0]      rq_lock,
    output logic [NREQ-1:0]      rq_done,
    output logic                 rq_error,
    output logic [31:0]          rq_rdata,
    output logic                 mst_valid,
    output logic [31:0]          mst_addr,
    output logic [31:0]          mst_wdata,
    output logic [3:0]           mst_write,
    output logic                 mst_lock,
    input  logic                 mst_ready,
    input  logic [31:0]          mst_rdata,
    output logic [2:0]           gnt_id
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [2:0]      rr_ptr, lock_id, gnt, win, rr_win, gnt_inc;
    logic            lock_vld, lock_hit, rr_hit, pick, lock_drop, xfer_ok, xfer_to;
    logic [TO_W-1:0] cnt;
    logic [3:0]      sum;
    logic [31:0]     sel_addr, sel_wdata;
    logic [3:0]      sel_write;
    logic            sel_lock;
    logic [NREQ-1:0] gnt_vec;

    // First valid requester at or after the rr pointer, wrapping at NREQ-1.
    always_comb begin
        rr_hit = 1'b0;
        rr_win = '0;
        sum    = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + 4'(i);
            if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
            if (!rr_hit && (rq_valid & (NREQ'(1) << sum[2:0])) != '0) begin
                rr_hit = 1'b1;
                rr_win = sum[2:0];
            end
        end
    end

    assign lock_hit = (rq_valid & (NREQ'(1) << lock_id)) != '0;
    assign gnt_vec  = NREQ'(1) << gnt;
    assign gnt_inc  = (gnt == 3'(NREQ-1)) ? 3'd0 : gnt + 3'd1;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = '0;
        sel_lock  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == 3'(i)) begin
                sel_addr  = rq_addr[32*i +: 32];
                sel_wdata = rq_wdata[32*i +: 32];
                sel_write = rq_write[4*i +: 4];
                sel_lock  = rq_lock[i];
            end
        end
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pick      = 1'b0;
        win       = rr_win;
        lock_drop = 1'b0;
        xfer_ok   = 1'b0;
        xfer_to   = 1'b0;
        case (state)
            IDLE: begin
                if (lock_vld && lock_hit) begin
                    pick = 1'b1;
                    win  = lock_id;
                end else begin
                    // An owner that stopped requesting forfeits the lock immediately.
                    lock_drop = lock_vld;
                    pick      = rr_hit;
                end
                if (pick) state_nx = LOAD;
            end
            LOAD: state_nx = BUSY;
            BUSY: begin
                if (mst_ready)                         xfer_ok = 1'b1;
                else if (cnt == TO_W'(TIMEOUT - 1))    xfer_to = 1'b1;
                if (xfer_ok || xfer_to) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            rq_done   <= '0;
            rq_error  <= 1'b0;
            rq_rdata  <= '0;
            mst_valid <= 1'b0;
            mst_addr  <= '0;
            mst_wdata <= '0;
            mst_write <= '0;
            mst_lock  <= 1'b0;
            gnt_id    <= '0;
            gnt       <= '0;
            rr_ptr    <= '0;
            lock_vld  <= 1'b0;
            lock_id   <= '0;
            cnt       <= '0;
        end else begin
            rq_done  <= '0;
            rq_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock_drop) lock_vld <= 1'b0;
                    if (pick)      gnt      <= win;
                end
                LOAD: begin
                    mst_addr  <= sel_addr;
                    mst_wdata <= sel_wdata;
                    mst_write <= sel_write;
                    mst_lock  <= sel_lock;
                    gnt_id    <= gnt;
                    cnt       <= '0;
                    mst_valid <= 1'b1;
                end
                BUSY: begin
                    cnt <= cnt + TO_W'(1);
                    if (xfer_ok || xfer_to) begin
                        mst_valid <= 1'b0;
                        rq_done   <= gnt_vec;
                        rq_error  <= xfer_to;
                        rq_rdata  <= xfer_ok ? mst_rdata : 32'hFFFF_FFFF;
                        if (xfer_ok && mst_lock) begin
                            lock_vld <= 1'b1;
                            lock_id  <= gnt;
                        end else begin
                            lock_vld <= 1'b0;
                            rr_ptr   <= gnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_master_sched.sv
// tb/tb_nubus_master_sched.sv - directed and randomized bench for nubus_master_sched
module tb_nubus_master_sched;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      rq_valid = '0;
    logic [32*NREQ-1:0]   rq_addr = '0;
    logic [32*NREQ-1:0]   rq_wdata = '0;
    logic [4*NREQ-1:0]    rq_write = '0;
    logic [NREQ-1:0]      rq_lock = '0;
    logic [NREQ-1:0]      rq_done;
    logic                 rq_error;
    logic [31:0]          rq_rdata;
    logic                 mst_valid;
    logic [31:0]          mst_addr, mst_wdata;
    logic [3:0]           mst_write;
    logic                 mst_lock;
    logic                 mst_ready = 1'b0;
    logic [31:0]          mst_rdata = '0;
    logic [2:0]           gnt_id;

    nubus_master_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .nub_clkn(clk), .nub_resetn(rst_n),
        .rq_valid(rq_valid), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
        .rq_write(rq_write), .rq_lock(rq_lock),
        .rq_done(rq_done), .rq_error(rq_error), .rq_rdata(rq_rdata),
        .mst_valid(mst_valid), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
        .mst_write(mst_write), .mst_lock(mst_lock),
        .mst_ready(mst_ready), .mst_rdata(mst_rdata), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit sim_end = 1'b0;

    // Reference model: transfer age since grant (-1 idle, 0 load, k = k-th bus cycle, -2 done).
    int              m_age = -1, m_rr = 0, m_own = -1, m_gnt = 0;
    logic            exp_valid = 1'b0, exp_err = 1'b0, exp_lock = 1'b0;
    logic [31:0]     exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [3:0]      exp_write = '0;
    logic [NREQ-1:0] exp_done = '0;
    logic [2:0]      exp_gnt = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic wait_done(output logic [NREQ-1:0] who);
        bit seen = 1'b0;
        who = '0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (rq_done != '0) begin
                who  = rq_done;
                seen = 1'b1;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: no rq_done within 200 cycles at %0t", $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rq_valid  = '0;
        rq_lock   = '0;
        mst_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic new_req(input int i);
        rq_valid[i]          = 1'b1;
        rq_addr[32*i +: 32]  = $urandom;
        rq_wdata[32*i +: 32] = $urandom;
        rq_write[4*i +: 4]   = 4'($urandom_range(15, 0));
        rq_lock[i]           = ($urandom_range(2, 0) == 0);
    endtask

    initial begin
        fork
            // model thread
            while (!sim_end) begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_age = -1; m_rr = 0; m_own = -1; m_gnt = 0;
                    exp_valid = 0; exp_err = 0; exp_lock = 0; exp_addr = 0;
                    exp_wdata = 0; exp_rdata = 0; exp_write = 0; exp_done = 0; exp_gnt = 0;
                end else begin
                    exp_done = '0;
                    exp_err  = 1'b0;
                    if (m_age == -1) begin
                        if (m_own >= 0 && rq_valid[m_own]) begin
                            m_gnt = m_own;
                            m_age = 0;
                        end else begin
                            m_own = -1;
                            for (int k = 0; k < NREQ; k++)
                                if (m_age == -1 && rq_valid[(m_rr + k) % NREQ]) begin
                                    m_gnt = (m_rr + k) % NREQ;
                                    m_age = 0;
                                end
                        end
                    end else if (m_age == 0) begin
                        exp_addr  = rq_addr[32*m_gnt +: 32];
                        exp_wdata = rq_wdata[32*m_gnt +: 32];
                        exp_write = rq_write[4*m_gnt +: 4];
                        exp_lock  = rq_lock[m_gnt];
                        exp_gnt   = 3'(m_gnt);
                        exp_valid = 1'b1;
                        m_age     = 1;
                    end else if (m_age > 0) begin
                        if (mst_ready || m_age == TIMEOUT) begin
                            exp_valid = 1'b0;
                            exp_done  = NREQ'(1) << m_gnt;
                            exp_err   = !mst_ready;
                            exp_rdata = mst_ready ? mst_rdata : 32'hFFFF_FFFF;
                            if (mst_ready && exp_lock) m_own = m_gnt;
                            else begin
                                m_own = -1;
                                m_rr  = (m_gnt + 1) % NREQ;
                            end
                            m_age = -2;
                        end else m_age++;
                    end else m_age = -1;
                end
            end
            // compare thread
            while (!sim_end) begin
                @(negedge clk);
                if (rst_n && !sim_end) begin
                    chk("mst_valid", 32'(mst_valid), 32'(exp_valid));
                    chk("rq_done",   32'(rq_done),   32'(exp_done));
                    chk("rq_error",  32'(rq_error),  32'(exp_err));
                    chk("rq_rdata",  rq_rdata,       exp_rdata);
                    chk("mst_addr",  mst_addr,       exp_addr);
                    chk("mst_wdata", mst_wdata,      exp_wdata);
                    chk("mst_write", 32'(mst_write), 32'(exp_write));
                    chk("mst_lock",  32'(mst_lock),  32'(exp_lock));
                    chk("gnt_id",    32'(gnt_id),    32'(exp_gnt));
                end
            end
            // stimulus thread
            begin
                logic [NREQ-1:0] who;
                int lat, vcnt, guard;
                logic [NREQ-1:0] exp_seq [4];

                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("reset mst_valid", 32'(mst_valid), 32'd0);
                chk("reset rq_done",   32'(rq_done),   32'd0);
                chk("reset rq_error",  32'(rq_error),  32'd0);
                chk("reset rq_rdata",  rq_rdata,       32'd0);
                chk("reset gnt_id",    32'(gnt_id),    32'd0);
                chk("reset mst_addr",  mst_addr,       32'd0);

                // single read
                rq_addr[31:0]  = 32'hF900_0000;
                rq_write[3:0]  = 4'd0;
                rq_valid       = 3'b001;
                lat = 0;
                while (!mst_valid && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                chk("single latency", 32'(lat), 32'd2);
                chk("single mst_addr", mst_addr, 32'hF900_0000);
                repeat (2) @(negedge clk);
                mst_ready = 1'b1;
                mst_rdata = 32'h1234_5678;
                @(negedge clk);
                mst_ready = 1'b0;
                rq_valid  = '0;
                chk("single rq_done",  32'(rq_done), 32'b001);
                chk("single rq_rdata", rq_rdata,     32'h1234_5678);
                chk("single rq_error", 32'(rq_error), 32'd0);

                // contention
                do_reset();
                rq_addr[63:32] = 32'hF910_0000;
                rq_valid  = 3'b011;
                mst_ready = 1'b1;
                exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
                for (int k = 0; k < 4; k++) begin
                    wait_done(who);
                    chk($sformatf("contention grant %0d", k), 32'(who), 32'(exp_seq[k]));
                end
                rq_valid = '0;

                // lock
                do_reset();
                rq_valid  = 3'b011;
                rq_lock   = 3'b001;
                mst_ready = 1'b1;
                exp_seq = '{3'b001, 3'b001, 3'b001, 3'b010};
                for (int k = 0; k < 4; k++) begin
                    wait_done(who);
                    chk($sformatf("lock grant %0d", k), 32'(who), 32'(exp_seq[k]));
                    if (k == 1) rq_lock[0] = 1'b0;
                end
                rq_valid = '0;
                rq_lock  = '0;

                // timeout
                do_reset();
                rq_valid  = 3'b010;
                rq_lock   = 3'b010;
                vcnt = 0;
                who  = '0;
                guard = 0;
                while (who == '0 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                    if (mst_valid) vcnt++;
                    who = rq_done;
                end
                chk("timeout busy cycles", 32'(vcnt), 32'd16);
                chk("timeout rq_done",     32'(who), 32'b010);
                chk("timeout rq_error",    32'(rq_error), 32'd1);
                chk("timeout rq_rdata",    rq_rdata, 32'hFFFF_FFFF);
                rq_valid  = 3'b011;
                rq_lock   = '0;
                mst_ready = 1'b1;
                wait_done(who);
                chk("timeout lock cleared", 32'(who), 32'b001);
                rq_valid = '0;

                // race: ready on the last allowed cycle
                do_reset();
                rq_valid = 3'b001;
                vcnt  = 0;
                guard = 0;
                while (vcnt < 16 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                    if (mst_valid) vcnt++;
                end
                mst_ready = 1'b1;
                mst_rdata = 32'hA5A5_5A5A;
                @(negedge clk);
                mst_ready = 1'b0;
                rq_valid  = '0;
                chk("race rq_done",  32'(rq_done), 32'b001);
                chk("race rq_error", 32'(rq_error), 32'd0);
                chk("race rq_rdata", rq_rdata, 32'hA5A5_5A5A);

                // reset mid-transfer
                do_reset();
                rq_valid  = 3'b001;
                mst_ready = 1'b1;
                wait_done(who);
                chk("prereset grant", 32'(who), 32'b001);
                rq_valid  = 3'b010;
                mst_ready = 1'b0;
                guard = 0;
                while (!mst_valid && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
                chk("midreset mst_valid before", 32'(mst_valid), 32'd1);
                repeat (2) @(negedge clk);
                #2;
                rst_n    = 1'b0;
                rq_valid = '0;
                #1;
                chk("async reset mst_valid", 32'(mst_valid), 32'd0);
                @(negedge clk);
                chk("async reset rq_done", 32'(rq_done), 32'd0);
                rst_n     = 1'b1;
                rq_valid  = 3'b101;
                mst_ready = 1'b1;
                wait_done(who);
                chk("postreset rr from 0", 32'(who), 32'b001);
                rq_valid  = '0;
                mst_ready = 1'b0;

                // randomized traffic
                do_reset();
                for (int cyc = 0; cyc < 3000; cyc++) begin
                    @(negedge clk);
                    for (int i = 0; i < NREQ; i++) begin
                        if (rq_done[i]) begin
                            if ($urandom_range(1, 0) == 1) new_req(i);
                            else rq_valid[i] = 1'b0;
                        end else if (!rq_valid[i] && $urandom_range(3, 0) == 0) begin
                            new_req(i);
                        end
                    end
                    mst_ready = ($urandom_range(3, 0) == 0);
                    mst_rdata = $urandom;
                end
                rq_valid  = '0;
                mst_ready = 1'b1;
                repeat (40) @(negedge clk);
                sim_end = 1'b1;
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
